forwarding_hazard_unit: RTL and testbench

//  Producer side of the EX-stage forwarding/stall interface. Tracks in-flight destination registers,

---
 rtl/forwarding_hazard_unit_pkg.sv | 7 +
 rtl/forwarding_hazard_unit_fwd_select.sv | 17 +
 rtl/forwarding_hazard_unit.sv | 86 ++++++++
 tb/tb_forwarding_hazard_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/forwarding_hazard_unit_pkg.sv
// forwarding_hazard_unit_pkg: forward-select codes shared with the EX operand muxes, hazard FSM states
package forwarding_hazard_unit_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT} state_e;
endpackage

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// forwarding_hazard_unit_fwd_select: EX operand source for one specifier, ex_mem beats mem_wb, r0 never forwards
module forwarding_hazard_unit_fwd_select
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  ex_fwd,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  mem_fwd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  output logic [1:0]            sel
);
  always_comb
    sel = (ex_fwd && ex_rd != '0 && ex_rd == src) ? FWD_EXMEM :
          (mem_fwd && mem_rd != '0 && mem_rd == src) ? FWD_MEMWB : FWD_REG;
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: tracks in-flight writers, registers EX forward selects, drives stall/flush controls
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_mem_access,
  input  logic                   branch_taken,
  input  logic                   dmem_ready,
  output logic [1:0]             Forward_A,
  output logic [1:0]             Forward_B,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   id_ex_flush,
  output logic                   if_id_flush,
  output logic [STALL_CNT_W-1:0] stall_count
);
  state_e state, state_n;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_access;
  logic [REG_ADDR_W-1:0] ex_rd, mem_rd;
  logic mem_valid, mem_reg_write, mem_mem_access;
  logic freeze, hazard, flush, load_use, issue;
  logic [1:0] fwd_a, fwd_b;
  forwarding_hazard_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .src(id_rs), .ex_fwd(ex_valid && ex_reg_write), .ex_rd(ex_rd),
    .mem_fwd(mem_valid && mem_reg_write), .mem_rd(mem_rd), .sel(fwd_a)
  );
  forwarding_hazard_unit_fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .src(id_rt), .ex_fwd(ex_valid && ex_reg_write), .ex_rd(ex_rd),
    .mem_fwd(mem_valid && mem_reg_write), .mem_rd(mem_rd), .sel(fwd_b)
  );
  always_comb begin
    freeze = reset && mem_valid && mem_mem_access && !dmem_ready;
    hazard = id_valid && ex_valid && ex_mem_read && ex_rd != '0 && (ex_rd == id_rs || ex_rd == id_rt);
    flush = reset && !freeze && branch_taken;
    load_use = reset && !freeze && !branch_taken && state != LOAD_STALL && hazard;
    issue = id_valid && !flush && !load_use;
    pc_write = !(freeze || load_use);
    if_id_write = pc_write;
    id_ex_flush = flush || load_use;
    if_id_flush = flush;
    state_n = freeze ? MEM_WAIT : load_use ? LOAD_STALL : RUN;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
      ex_valid <= 1'b0;
      ex_rd <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_mem_access <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_access <= 1'b0;
      Forward_A <= FWD_REG;
      Forward_B <= FWD_REG;
      stall_count <= '0;
    end else begin
      state <= state_n;
      if (!pc_write && stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
      if (!freeze) begin
        mem_valid <= ex_valid;
        mem_rd <= ex_rd;
        mem_reg_write <= ex_reg_write;
        mem_mem_access <= ex_mem_access;
        ex_valid <= issue;
        ex_rd <= issue ? id_rd : '0;
        ex_reg_write <= issue && id_reg_write;
        ex_mem_read <= issue && id_mem_read;
        ex_mem_access <= issue && id_mem_access;
        Forward_A <= issue ? fwd_a : FWD_REG;
        Forward_B <= issue ? fwd_b : FWD_REG;
      end
    end
  end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: directed vector table plus randomized run against an instruction-level model
module tb_forwarding_hazard_unit;
  logic clk = 1'b0;
  logic reset, id_valid, id_reg_write, id_mem_read, id_mem_access, branch_taken, dmem_ready;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] Forward_A, Forward_B;
  logic pc_write, if_id_write, id_ex_flush, if_id_flush;
  logic [15:0] stall_count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  forwarding_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_access(id_mem_access),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready), .Forward_A(Forward_A), .Forward_B(Forward_B),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_flush(id_ex_flush), .if_id_flush(if_id_flush),
    .stall_count(stall_count)
  );
  typedef struct {
    bit r, v; int rs, rt, rd; bit rw, mr, ma, br, rdy;
    bit pc, xf, ff; int fa, fb, cnt;
  } vec_t;
  typedef struct {bit v; int rd; bit rw, mr, ma;} ins_t;
  vec_t tbl[$];
  ins_t pipe[2];
  int m_fa, m_fb, m_cnt;
  bit m_ls;
  function automatic vec_t mk(bit r, bit v, int rs, int rt, int rd, bit rw, bit mr, bit ma, bit br, bit rdy,
                              bit pc, bit xf, bit ff, int fa, int fb, int cnt);
    vec_t t;
    t = '{r, v, rs, rt, rd, rw, mr, ma, br, rdy, pc, xf, ff, fa, fb, cnt};
    return t;
  endfunction
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic drive(input bit r, input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit mr, input bit ma, input bit br, input bit rdy);
    reset = r;
    id_valid = v;
    id_rs = 5'(rs);
    id_rt = 5'(rt);
    id_rd = 5'(rd);
    id_reg_write = rw;
    id_mem_read = mr;
    id_mem_access = ma;
    branch_taken = br;
    dmem_ready = rdy;
  endtask
  task automatic apply_vec(input vec_t t, input int i);
    drive(t.r, t.v, t.rs, t.rt, t.rd, t.rw, t.mr, t.ma, t.br, t.rdy);
    #1;
    chk($sformatf("vec%0d pc_write", i), int'(pc_write), int'(t.pc));
    chk($sformatf("vec%0d if_id_write", i), int'(if_id_write), int'(t.pc));
    chk($sformatf("vec%0d id_ex_flush", i), int'(id_ex_flush), int'(t.xf));
    chk($sformatf("vec%0d if_id_flush", i), int'(if_id_flush), int'(t.ff));
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d Forward_A", i), int'(Forward_A), t.fa);
    chk($sformatf("vec%0d Forward_B", i), int'(Forward_B), t.fb);
    chk($sformatf("vec%0d stall_count", i), int'(stall_count), t.cnt);
    @(negedge clk);
  endtask
  function automatic int fwd(int src);
    for (int s = 0; s < 2; s++)
      if (pipe[s].v && pipe[s].rw && pipe[s].rd != 0 && pipe[s].rd == src) return 2 - s;
    return 0;
  endfunction
  task automatic rnd_cycle(input bit r, input int n);
    bit v, rw, mr, ma, br, rdy, frozen, lu, bf, issue;
    int rs, rt, rd, na, nb;
    v = $urandom_range(9) < 8;
    rs = $urandom_range(3);
    rt = $urandom_range(3);
    rd = $urandom_range(3);
    mr = $urandom_range(3) == 0;
    ma = mr || $urandom_range(3) == 0;
    rw = mr || $urandom_range(1) == 1;
    br = $urandom_range(7) == 0;
    rdy = $urandom_range(9) < 7;
    drive(r, v, rs, rt, rd, rw, mr, ma, br, rdy);
    #1;
    frozen = r && pipe[1].v && pipe[1].ma && !rdy;
    lu = r && !frozen && !br && !m_ls && v && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
         (pipe[0].rd == rs || pipe[0].rd == rt);
    bf = r && !frozen && br;
    chk($sformatf("rnd%0d pc_write", n), int'(pc_write), int'(!(frozen || lu)));
    chk($sformatf("rnd%0d if_id_write", n), int'(if_id_write), int'(!(frozen || lu)));
    chk($sformatf("rnd%0d id_ex_flush", n), int'(id_ex_flush), int'(bf || lu));
    chk($sformatf("rnd%0d if_id_flush", n), int'(if_id_flush), int'(bf));
    @(posedge clk);
    if (!r) begin
      pipe[0] = '{0, 0, 0, 0, 0};
      pipe[1] = '{0, 0, 0, 0, 0};
      m_fa = 0;
      m_fb = 0;
      m_cnt = 0;
      m_ls = 0;
    end else begin
      if ((frozen || lu) && m_cnt < 65535) m_cnt++;
      if (!frozen) begin
        issue = v && !bf && !lu;
        na = issue ? fwd(rs) : 0;
        nb = issue ? fwd(rt) : 0;
        pipe[1] = pipe[0];
        pipe[0] = issue ? '{1, rd, rw, mr, ma} : '{0, 0, 0, 0, 0};
        m_fa = na;
        m_fb = nb;
      end
      m_ls = lu;
    end
    #1;
    chk($sformatf("rnd%0d Forward_A", n), int'(Forward_A), m_fa);
    chk($sformatf("rnd%0d Forward_B", n), int'(Forward_B), m_fb);
    chk($sformatf("rnd%0d stall_count", n), int'(stall_count), m_cnt);
    @(negedge clk);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 2, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 1, 4, 1, 0, 0, 0, 1, 1, 0, 0, 2, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 3, 5, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 6, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 2, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 2, 6, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 2, 2, 6, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 1, 0, 0, 7, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 6, 8, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 7, 8, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 1, 7, 8, 9, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(1, 1, 7, 8, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(1, 1, 7, 8, 9, 1, 0, 0, 0, 1, 1, 0, 0, 1, 2, 4));
    tbl.push_back(mk(1, 1, 0, 0, 10, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 1, 10, 0, 11, 1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 4));
    tbl.push_back(mk(1, 1, 10, 10, 12, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4));
    foreach (tbl[i]) apply_vec(tbl[i], i);
    apply_vec(mk(1, 1, 0, 0, 2, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 4), 100);
    apply_vec(mk(1, 1, 2, 0, 5, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 5), 101);
    apply_vec(mk(0, 1, 2, 0, 5, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), 102);
    apply_vec(mk(1, 1, 2, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 103);
    rnd_cycle(0, 0);
    for (int n = 1; n < 3000; n++) rnd_cycle($urandom_range(99) != 0, n);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
